// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1x8 credit-based demux dispatcher.
package demux_pkg;

   localparam int NCH  = 8;
   localparam int SELW = 3;

   typedef enum logic {IDLE, SEND} disp_state_t;

   // Returns {found, idx}: first eligible channel at or after ptr, wrapping 7 -> 0.
   function automatic logic [SELW:0] rr_pick(input logic [SELW-1:0] ptr,
                                             input logic [NCH-1:0]  eligible);
      logic            found;
      logic [SELW-1:0] idx;
      logic [SELW-1:0] cand;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NCH; k++) begin
         cand = ptr + SELW'(k);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Producer/consumer bundle of the dispatcher: upstream valid/ready, per-lane valid/ready, credits.
interface demux_dispatch_ctrl_if #(
   parameter int DW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [2:0]    in_dest;
   logic          in_mode;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready;
   logic [DW-1:0] out_data;
   logic [7:0]    credit_ret;
   logic          busy;
   logic          credit_err;

   modport master (
      output in_valid, in_data, in_dest, in_mode, out_ready, credit_ret,
      input  in_ready, out_valid, out_data, busy, credit_err
   );

   modport slave (
      input  in_valid, in_data, in_dest, in_mode, out_ready, credit_ret,
      output in_ready, out_valid, out_data, busy, credit_err
   );
endinterface

// File: rtl/demux_1_8.sv
// One-hot 1-to-8 decode of a single enable onto the lane selected by sel.
module demux_1_8 (
   input  logic       in,
   input  logic [2:0] sel,
   output logic [7:0] o
);
   assign o = in ? (8'b1 << sel) : 8'b0;
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Credit-based dispatcher: routes upstream words to one of 8 lanes by address or round-robin.
//
//  state | meaning
//  IDLE  | waiting for an upstream word whose target lane has credit
//  SEND  | holding the latched word on the selected lane until that lane is ready
module demux_dispatch_ctrl
   import demux_pkg::*;
#(
   parameter int DW      = 8,
   parameter int CREDITS = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   demux_dispatch_ctrl_if.slave bus
);

   disp_state_t           state_q, state_d;
   logic [DW-1:0]         data_q;
   logic [SELW-1:0]       sel_q;
   logic [SELW-1:0]       rr_ptr_q;
   logic [SELW-1:0]       target;
   logic [SELW:0]         pick;
   logic                  target_ok;
   logic                  in_ready;
   logic                  busy;
   logic                  accept;
   logic                  send_active;
   logic                  credit_err_q;
   logic [NCH-1:0]        eligible;
   logic [NCH-1:0]        dec;
   logic [NCH-1:0]        ret_full;
   logic [NCH-1:0][3:0]   credit_q;

   always_comb begin
      pick      = rr_pick(rr_ptr_q, eligible);
      target    = bus.in_dest;
      target_ok = eligible[bus.in_dest];
      if (bus.in_mode) begin
         target    = pick[SELW-1:0];
         target_ok = pick[SELW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid && target_ok) state_d = SEND;
         SEND:    if (bus.out_ready[sel_q])      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = 1'b0;
      busy        = 1'b0;
      send_active = 1'b0;
      case (state_q)
         IDLE:    in_ready = target_ok;
         SEND:    begin
            busy        = 1'b1;
            send_active = 1'b1;
         end
         default: ;
      endcase
   end

   assign accept = in_ready && bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q       <= '0;
         sel_q        <= '0;
         rr_ptr_q     <= '0;
         credit_err_q <= 1'b0;
      end else begin
         if (accept) begin
            data_q <= bus.in_data;
            sel_q  <= target;
            if (bus.in_mode) rr_ptr_q <= target + 1'b1;
         end
         if (|ret_full) credit_err_q <= 1'b1;
      end
   end

   // A return and a grant on the same lane in one cycle cancel out.
   for (genvar i = 0; i < NCH; i++) begin : g_credit
      logic [3:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= 4'(CREDITS);
         end else if (bus.credit_ret[i] && !dec[i]) begin
            if (cnt_q != 4'(CREDITS)) cnt_q <= cnt_q + 4'd1;
         end else if (dec[i] && !bus.credit_ret[i]) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
      assign dec[i]      = accept && (target == SELW'(i));
      assign ret_full[i] = bus.credit_ret[i] && !dec[i] && (cnt_q == 4'(CREDITS));
      assign eligible[i] = (cnt_q != 4'd0);
      assign credit_q[i] = cnt_q;
   end

   demux_1_8 u_demux (
      .in  (send_active),
      .sel (sel_q),
      .o   (bus.out_valid)
   );

   assign bus.out_data   = data_q;
   assign bus.in_ready   = in_ready;
   assign bus.busy       = busy;
   assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: reference model plus word scoreboard.
module tb_demux_dispatch_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_dispatch_ctrl_if #(.DW(8)) bus ();

   demux_dispatch_ctrl #(.DW(8), .CREDITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      logic [2:0] ch;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   obs_ch[$];

   logic       m_send;
   logic [2:0] m_sel;
   logic [2:0] m_rr;
   logic [3:0] m_cred [8];
   logic       m_err;
   logic       m_ok;
   logic       m_ready;
   logic [2:0] m_tgt;
   logic [2:0] m_c;

   always_comb begin
      m_c   = 3'd0;
      m_tgt = bus.in_dest;
      m_ok  = (m_cred[bus.in_dest] != 4'd0);
      if (bus.in_mode) begin
         m_ok  = 1'b0;
         m_tgt = 3'd0;
         for (int k = 7; k >= 0; k--) begin
            m_c = m_rr + 3'(k);
            if (m_cred[m_c] != 4'd0) begin
               m_ok  = 1'b1;
               m_tgt = m_c;
            end
         end
      end
      m_ready = !m_send && m_ok;
   end

   always @(posedge clk or negedge rst_n) begin : model
      logic       acc;
      logic [2:0] tgt;
      logic [7:0] dat;
      logic       mode;
      logic       d, r;
      if (!rst_n) begin
         m_send = 1'b0;
         m_sel  = 3'd0;
         m_rr   = 3'd0;
         m_err  = 1'b0;
         for (int i = 0; i < 8; i++) m_cred[i] = 4'd4;
         sb.delete();
      end else begin
         acc  = m_ready && bus.in_valid;
         tgt  = m_tgt;
         dat  = bus.in_data;
         mode = bus.in_mode;
         for (int i = 0; i < 8; i++) begin
            d = acc && (tgt == 3'(i));
            r = bus.credit_ret[i];
            if (r && !d) begin
               if (m_cred[i] == 4'd4) m_err = 1'b1;
               else                   m_cred[i] = m_cred[i] + 4'd1;
            end else if (d && !r) begin
               m_cred[i] = m_cred[i] - 4'd1;
            end
         end
         if (m_send) begin
            if (bus.out_ready[m_sel]) m_send = 1'b0;
         end else if (acc) begin
            sb.push_back('{tgt, dat});
            m_sel  = tgt;
            m_send = 1'b1;
            if (mode) m_rr = tgt + 3'd1;
         end
      end
   end

   function automatic int oh_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 32'(bus.in_ready), 32'(m_ready));
         check("busy", 32'(bus.busy), 32'(m_send));
         check("credit_err", 32'(bus.credit_err), 32'(m_err));
         if (m_send) begin
            if (sb.size() == 0) begin
               check("sb_size", 32'(sb.size()), 32'd1);
            end else begin
               check("out_valid", 32'(bus.out_valid), 32'(8'b1 << sb[0].ch));
               check("out_data", 32'(bus.out_data), 32'(sb[0].data));
               if (bus.out_ready[sb[0].ch]) begin
                  obs_ch.push_back(oh_idx(bus.out_valid));
                  void'(sb.pop_front());
               end
            end
         end else begin
            check("out_valid_idle", 32'(bus.out_valid), 32'd0);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic start_word(input logic mode, input logic [2:0] dest, input logic [7:0] data);
      bus.in_valid = 1'b1;
      bus.in_mode  = mode;
      bus.in_dest  = dest;
      bus.in_data  = data;
   endtask

   task automatic finish_word();
      logic acc;
      acc = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         acc = m_ready;
         @(posedge clk);
         #2;
         if (acc) break;
      end
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic mode, input logic [2:0] dest, input logic [7:0] data);
      start_word(mode, dest, data);
      finish_word();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_send && n < 50) begin
         cycles(1);
         n++;
      end
      if (m_send) check("idle_timeout", 32'(m_send), 32'd0);
   endtask

   task automatic pulse_ret(input logic [7:0] mask);
      bus.credit_ret = mask;
      cycles(1);
      bus.credit_ret = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      bus.in_dest    = 3'd0;
      bus.in_mode    = 1'b0;
      bus.out_ready  = 8'hFF;
      bus.credit_ret = 8'h00;
      cycles(2);
      rst_n = 1'b1;
      cycles(1);

      // reset state, then reset asserted while a word is held in SEND
      for (int i = 0; i < 8; i++) check("rst_credit", 32'(dut.credit_q[i]), 32'd4);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      bus.out_ready = 8'h00;
      send_word(1'b0, 3'd3, 8'h11);
      cycles(2);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_async_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #2;
      bus.out_ready = 8'hFF;
      rst_n = 1'b1;
      cycles(1);
      check("rst_credit3", 32'(dut.credit_q[3]), 32'd4);
      check("rst_ready_after", 32'(bus.in_ready), 32'd1);

      // addressed word to lane 5
      send_word(1'b0, 3'd5, 8'hA5);
      #1;
      check("addr_out_valid", 32'(bus.out_valid), 32'h20);
      check("addr_out_data", 32'(bus.out_data), 32'hA5);
      check("addr_credit5", 32'(dut.credit_q[5]), 32'd3);
      wait_idle();

      // credit stall on lane 2, released by one credit return
      for (int i = 0; i < 4; i++) send_word(1'b0, 3'd2, 8'h50 + 8'(i));
      wait_idle();
      start_word(1'b0, 3'd2, 8'h54);
      cycles(2);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_credit2", 32'(dut.credit_q[2]), 32'd0);
      pulse_ret(8'h04);
      finish_word();
      wait_idle();
      check("stall_sb_drained", 32'(sb.size()), 32'd0);

      // round-robin order over 10 words
      do_reset();
      obs_ch.delete();
      for (int i = 0; i < 10; i++) send_word(1'b1, 3'd0, 8'h80 + 8'(i));
      wait_idle();
      check("rr_count", 32'(obs_ch.size()), 32'd10);
      if (obs_ch.size() == 10)
         for (int i = 0; i < 10; i++) check("rr_order", 32'(obs_ch[i]), 32'(i % 8));
      check("rr_ptr_end", 32'(dut.rr_ptr_q), 32'd2);

      // round-robin skips drained lanes 1 and 2
      do_reset();
      obs_ch.delete();
      for (int i = 0; i < 4; i++) send_word(1'b0, 3'd1, 8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) send_word(1'b0, 3'd2, 8'h20 + 8'(i));
      send_word(1'b1, 3'd7, 8'h30);
      wait_idle();
      check("skip_rr_ptr1", 32'(dut.rr_ptr_q), 32'd1);
      send_word(1'b1, 3'd7, 8'h31);
      wait_idle();
      check("skip_count", 32'(obs_ch.size()), 32'd10);
      if (obs_ch.size() == 10) check("skip_grant", 32'(obs_ch[9]), 32'd3);
      check("skip_rr_ptr4", 32'(dut.rr_ptr_q), 32'd4);

      // backpressure hold, credit overflow, simultaneous return and grant
      do_reset();
      bus.out_ready = 8'h00;
      send_word(1'b0, 3'd6, 8'h3C);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(bus.out_valid), 32'h40);
         check("bp_out_data", 32'(bus.out_data), 32'h3C);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #2;
      bus.out_ready = 8'hFF;
      wait_idle();
      check("pre_err", 32'(bus.credit_err), 32'd0);
      pulse_ret(8'h01);
      check("ovf_err", 32'(bus.credit_err), 32'd1);
      check("ovf_credit0", 32'(dut.credit_q[0]), 32'd4);
      start_word(1'b0, 3'd4, 8'h77);
      bus.credit_ret = 8'h10;
      finish_word();
      bus.credit_ret = 8'h00;
      check("same_cycle_credit4", 32'(dut.credit_q[4]), 32'd4);
      wait_idle();
      cycles(2);
      check("err_sticky", 32'(bus.credit_err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
